// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns a decoded field bundle back into a 32-bit word,
// flags unencodable bundles as NOP+error, and buffers results in a 2-entry FIFO.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [3:0] {
    C_LUI    = 4'd0,
    C_AUIPC  = 4'd1,
    C_JAL    = 4'd2,
    C_JALR   = 4'd3,
    C_LOAD   = 4'd4,
    C_STORE  = 4'd5,
    C_OPIMM  = 4'd6,
    C_OP     = 4'd7,
    C_BRANCH = 4'd8
  } op_class_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  op_class_e   cls;
  logic        imm_i_ok, imm_b_ok, imm_j_ok, is_shift, alt_ok;
  logic [31:0] enc_inst, enc_word;
  logic        enc_err;

  logic [31:0] fifo_inst [2];
  logic        fifo_err  [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_nxt;
  logic        in_ready_q;
  logic [7:0]  err_cnt_q;
  logic        push, pop;

  assign cls      = op_class_e'(op_class);
  assign imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign imm_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
  assign alt_ok   = ~alt
                  || (cls == C_OP    && (funct3 == 3'd0 || funct3 == 3'd5))
                  || (cls == C_OPIMM && funct3 == 3'd5);

  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (cls)
      C_LUI, C_AUIPC: begin
        enc_inst = {imm[31:12], rd, (cls == C_LUI) ? 7'b0110111 : 7'b0010111};
        enc_err  = |imm[11:0];
      end
      C_JAL: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        enc_err  = ~imm_j_ok;
      end
      C_JALR: begin
        enc_inst = {imm[11:0], rs1, funct3, rd, 7'b1100111};
        enc_err  = ~imm_i_ok || (funct3 != 3'd0);
      end
      C_LOAD: begin
        enc_inst = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        enc_err  = ~imm_i_ok || (funct3 == 3'd3) || (funct3 > 3'd5);
      end
      C_STORE: begin
        enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        enc_err  = ~imm_i_ok || (funct3 > 3'd2);
      end
      C_OPIMM: begin
        // Shift immediates carry shamt only; alt lands in funct7[5] (bit 30).
        if (is_shift) begin
          enc_inst = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
          enc_err  = |imm[31:5];
        end else begin
          enc_inst = {imm[11:0], rs1, funct3, rd, 7'b0010011};
          enc_err  = ~imm_i_ok;
        end
      end
      C_OP: begin
        enc_inst = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
      end
      C_BRANCH: begin
        enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        enc_err  = ~imm_b_ok || (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      default: enc_err = 1'b1;
    endcase
    if (!alt_ok) enc_err = 1'b1;
  end

  assign enc_word = enc_err ? NOP : enc_inst;

  assign in_ready  = in_ready_q;
  assign out_valid = (count != 2'd0);
  assign out_inst  = fifo_inst[rd_ptr];
  assign out_err   = fifo_err[rd_ptr];
  assign err_count = err_cnt_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 2'd1;
    else if (!push && pop) count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_inst[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      in_ready_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_inst[wr_ptr] <= enc_word;
        fifo_err[wr_ptr]  <= enc_err;
        wr_ptr            <= ~wr_ptr;
        if (enc_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      // Registered from next count so in_ready never sees out_ready combinationally.
      in_ready_q <= (count_nxt != 2'd2);
    end
  end

endmodule
